// File: rtl/c64_debug_pkg.sv
// Shared types and constants for the C64 debug bus responder and future
// DMA masters that reuse the CPU halt logic.
package c64_debug_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HALT   = 3'd1,
    OWN    = 3'd2,
    ACCESS = 3'd3,
    ACK    = 3'd4,
    DROP   = 3'd5
  } dbg_state_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } dbg_op_e;

  localparam logic [7:0]  ACK_WRITE_CODE         = 8'h06;
  localparam logic [7:0]  ABORT_DATA_DEFAULT     = 8'hFF;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1000000;

  function automatic dbg_op_e op_from_we(input logic we);
    return we ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/c64_cpu_halt.sv
// 6510 RDY driver with halted detection. RDY drops on a halt request; the
// CPU is only known to be stopped once a read cycle (cpu_rw=1) ends with RDY
// low, because the 6510 ignores RDY during its write cycles.
module c64_cpu_halt (
  input  logic clk,
  input  logic reset_n,
  input  logic i_halt_req,
  input  logic i_release,
  input  logic i_wait,
  input  logic i_phi2_fall,
  input  logic i_cpu_rw,
  output logic o_cpu_rdy,
  output logic o_halted
);

  logic r_rdy;

  // RDY register: release wins over a new halt request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdy <= 1'b1;
    end else if (i_release) begin
      r_rdy <= 1'b1;
    end else if (i_halt_req) begin
      r_rdy <= 1'b0;
    end
  end

  assign o_halted  = i_wait & i_phi2_fall & i_cpu_rw & ~r_rdy;
  assign o_cpu_rdy = r_rdy;

endmodule

// File: rtl/c64_debug_bus_responder.sv
// Bus-side responder for debug accesses: latches one request, halts the
// 6510, takes one free phi2 slot, performs the access and pulses ack.
// Optional feature macro: C64_DEBUG_TIMEOUT_EN (forced abort while waiting
// for the CPU or a free slot).
//
// state  | meaning
// IDLE   | waiting for debug_request
// HALT   | RDY low, waiting for a read cycle to end so the CPU is stopped
// OWN    | CPU halted, waiting for a phi2 slot the VIC does not own
// ACCESS | responder drives the bus for exactly one phi2 slot
// ACK    | ack pulse cycle
// DROP   | waiting for the initiator to release a held request
module c64_debug_bus_responder
  import c64_debug_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter logic [7:0]  ABORT_DATA     = ABORT_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] debug_addr,
  input  logic [7:0]  debug_data_i,
  input  logic        debug_we,
  input  logic        debug_request,
  output logic        debug_ack,
  output logic [7:0]  debug_data_o,
  input  logic        phi2_rise,
  input  logic        phi2_fall,
  input  logic        cpu_rw,
  input  logic        vic_ba,
  input  logic [7:0]  mem_rdata,
  output logic        cpu_rdy,
  output logic        bus_own,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we
);

  dbg_state_e  r_state;
  dbg_state_e  w_state_nxt;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  dbg_op_e     r_op;
  logic        r_bus_own;
  logic        r_mem_we;
  logic [15:0] r_mem_addr;
  logic [7:0]  r_mem_wdata;
  logic        r_ack;
  logic [7:0]  r_rdata;

  logic        w_accept;
  logic        w_slot_start;
  logic        w_slot_end;
  logic        w_abort;
  logic        w_release;
  logic        w_halt_wait;
  logic        w_halted;

  assign w_halt_wait = (r_state == HALT);
  assign w_release   = w_slot_end | w_abort;

  c64_cpu_halt u_cpu_halt (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_halt_req  (w_accept),
    .i_release   (w_release),
    .i_wait      (w_halt_wait),
    .i_phi2_fall (phi2_fall),
    .i_cpu_rw    (cpu_rw),
    .o_cpu_rdy   (cpu_rdy),
    .o_halted    (w_halted)
  );

`ifdef C64_DEBUG_TIMEOUT_EN
  logic [31:0] r_cnt;
  logic        w_waiting;

  assign w_waiting = (r_state == HALT) || (r_state == OWN);
  assign w_abort   = w_waiting && (r_cnt == TIMEOUT_CYCLES - 32'd1);

  // Wait-time counter, restarted for every accepted request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (w_waiting && !w_abort) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end
`else
  logic w_unused_cfg;

  assign w_abort      = 1'b0;
  assign w_unused_cfg = ^{TIMEOUT_CYCLES, ABORT_DATA};
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; a coincident phi2_fall masks phi2_rise in OWN
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_slot_start = 1'b0;
    w_slot_end   = 1'b0;
    case (r_state)
      IDLE: begin
        if (debug_request) begin
          w_accept    = 1'b1;
          w_state_nxt = HALT;
        end
      end
      HALT: begin
        if (w_abort) begin
          w_state_nxt = ACK;
        end else if (w_halted) begin
          w_state_nxt = OWN;
        end
      end
      OWN: begin
        if (w_abort) begin
          w_state_nxt = ACK;
        end else if (phi2_rise && !phi2_fall && vic_ba) begin
          w_slot_start = 1'b1;
          w_state_nxt  = ACCESS;
        end
      end
      ACCESS: begin
        if (phi2_fall) begin
          w_slot_end  = 1'b1;
          w_state_nxt = ACK;
        end
      end
      ACK: begin
        w_state_nxt = debug_request ? DROP : IDLE;
      end
      DROP: begin
        if (!debug_request) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Request capture; later changes on the debug inputs are ignored
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_op    <= OP_NONE;
    end else if (w_accept) begin
      r_addr  <= debug_addr;
      r_wdata <= debug_data_i;
      r_op    <= op_from_we(debug_we);
    end
  end

  // Bus drive for the single owned slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bus_own   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_slot_start) begin
      r_bus_own   <= 1'b1;
      r_mem_addr  <= r_addr;
      r_mem_wdata <= r_wdata;
      r_mem_we    <= (r_op == OP_WRITE);
    end else if (w_slot_end) begin
      r_bus_own   <= 1'b0;
      r_mem_we    <= 1'b0;
    end
  end

  // Completion pulse and read-data capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= w_slot_end | w_abort;
      if (w_slot_end && (r_op == OP_READ)) begin
        r_rdata <= mem_rdata;
      end
`ifdef C64_DEBUG_TIMEOUT_EN
      if (w_abort) begin
        r_rdata <= ABORT_DATA;
      end
`endif
    end
  end

  assign debug_ack    = r_ack;
  assign debug_data_o = r_rdata;
  assign bus_own      = r_bus_own;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign mem_we       = r_mem_we;

endmodule
